// File: rtl/iseq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iseq_pkg: opcode constants and loader state encoding                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package iseq_pkg;

    localparam int          OPC_HI    = 31;
    localparam int          OPC_LO    = 28;
    localparam logic [3:0]  OPC_END   = 4'hF;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        PAD     = 3'd1,
        KICK    = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } state_t;

    function automatic logic is_end(input logic [31:0] instr);
        return instr[OPC_HI:OPC_LO] == OPC_END;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iseq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iseq_fifo: first-word-fall-through FIFO, head word shown while       |
// | not empty and forced to zero when empty                              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module iseq_fifo #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   c_depth    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one  = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign empty   = (r_count == '0);
    assign full    = (r_count == c_depth);
    assign count   = r_count;
    assign w_wr    = wr_en & ~full;
    assign w_rd    = rd_en & ~empty;
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_rd) r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/iseq_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iseq_loader: deals host instructions alternately into two slot       |
// | FIFOs, pads odd sequences with a NOP and kicks the dispatcher        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module iseq_loader
    import iseq_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        process_iseq,
    input  logic        dispatcher_busy,
    input  logic        instr0_fifo_rd,
    output logic        instr0_fifo_empty,
    output logic [31:0] instr0_fifo_data,
    input  logic        instr1_fifo_rd,
    output logic        instr1_fifo_empty,
    output logic [31:0] instr1_fifo_data,
    output logic        overflow_flush
);

    localparam int AW = $clog2(DEPTH);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_slot;
    logic        w_slot_nxt;
    logic        r_load_rdy;
    logic        r_overflow;
    logic        w_ovf_set;
    logic        w_accept;
    logic        w_wr0;
    logic        w_wr1;
    logic [31:0] w_wr_data;
    logic        w_full0;
    logic        w_full1;
    logic        w_both_full;
    logic [AW:0] w_count0;
    logic [AW:0] w_count1;

    // Fullness gates the registered LOAD flag so a full pair never accepts
    assign w_both_full    = w_full0 & w_full1;
    assign in_ready       = r_load_rdy & ~w_both_full;
    assign w_accept       = in_valid & in_ready;
    assign process_iseq   = (r_state == KICK);
    assign overflow_flush = r_overflow;

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_wr0       = 1'b0;
        w_wr1       = 1'b0;
        w_wr_data   = in_data;
        w_ovf_set   = 1'b0;
        case (r_state)
            LOAD: begin
                if (w_both_full) begin
                    w_state_nxt = KICK;
                    w_ovf_set   = 1'b1;
                end else if (w_accept) begin
                    if (is_end(in_data)) begin
                        w_state_nxt = r_slot ? PAD : KICK;
                    end else begin
                        w_wr0      = ~r_slot;
                        w_wr1      = r_slot;
                        w_slot_nxt = ~r_slot;
                    end
                end
            end
            PAD: begin
                w_wr1       = 1'b1;
                w_wr_data   = INSTR_NOP;
                w_slot_nxt  = 1'b0;
                w_state_nxt = KICK;
            end
            KICK:    w_state_nxt = WAIT_HI;
            WAIT_HI: if (dispatcher_busy)  w_state_nxt = WAIT_LO;
            WAIT_LO: if (!dispatcher_busy) w_state_nxt = LOAD;
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LOAD;
            r_slot     <= 1'b0;
            r_load_rdy <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_slot     <= w_slot_nxt;
            r_load_rdy <= (w_state_nxt == LOAD);
            if (w_ovf_set) r_overflow <= 1'b1;
        end
    end

    iseq_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr0),
        .wr_data (w_wr_data),
        .rd_en   (instr0_fifo_rd),
        .rd_data (instr0_fifo_data),
        .empty   (instr0_fifo_empty),
        .full    (w_full0),
        .count   (w_count0)
    );

    iseq_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr1),
        .wr_data (w_wr_data),
        .rd_en   (instr1_fifo_rd),
        .rd_data (instr1_fifo_data),
        .empty   (instr1_fifo_empty),
        .full    (w_full1),
        .count   (w_count1)
    );

endmodule
`default_nettype wire

// File: tb/tb_iseq_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_iseq_loader: scoreboard bench with a model dispatcher             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_iseq_loader;

    localparam int          TB_DEPTH = 4;
    localparam logic [31:0] W_END    = 32'hF000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        process_iseq;
    logic        dispatcher_busy;
    logic        instr0_fifo_rd;
    logic        instr0_fifo_empty;
    logic [31:0] instr0_fifo_data;
    logic        instr1_fifo_rd;
    logic        instr1_fifo_empty;
    logic [31:0] instr1_fifo_data;
    logic        overflow_flush;

    logic man_rd0 = 1'b0;
    logic disp_rd0 = 1'b0;
    logic disp_rd1 = 1'b0;
    logic disp_active = 1'b0;
    assign instr0_fifo_rd = man_rd0 | disp_rd0;
    assign instr1_fifo_rd = disp_rd1;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    int          kick_q[$];
    logic        m_slot = 1'b0;
    logic        m_ovf = 1'b0;

    iseq_loader #(.DEPTH(TB_DEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .process_iseq      (process_iseq),
        .dispatcher_busy   (dispatcher_busy),
        .instr0_fifo_rd    (instr0_fifo_rd),
        .instr0_fifo_empty (instr0_fifo_empty),
        .instr0_fifo_data  (instr0_fifo_data),
        .instr1_fifo_rd    (instr1_fifo_rd),
        .instr1_fifo_empty (instr1_fifo_empty),
        .instr1_fifo_data  (instr1_fifo_data),
        .overflow_flush    (overflow_flush)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference behaviour for one accepted word in cycle t
    task automatic model(input logic [31:0] w, input int t);
        logic [3:0] opc;
        opc = w[31:28];
        if (opc == 4'hF) begin
            if (m_slot) begin
                exp1.push_back(32'h0);
                kick_q.push_back(t + 2);
            end else begin
                kick_q.push_back(t + 1);
            end
            m_slot = 1'b0;
        end else begin
            if (m_slot) exp1.push_back(w);
            else        exp0.push_back(w);
            m_slot = ~m_slot;
            if (!m_slot && exp0.size() == TB_DEPTH && exp1.size() == TB_DEPTH) begin
                kick_q.push_back(t + 2);
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic send(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            model(w, cyc);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (in_ready && !disp_active && kick_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
        check("drain0_left", exp0.size(), 32'd0);
        check("drain1_left", exp1.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: pops and kick pulses compared against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (instr0_fifo_rd && !instr0_fifo_empty) begin
                if (exp0.size() == 0) check("fifo0_unexpected", instr0_fifo_data, 32'hxxxx_xxxx);
                else check("fifo0_data", instr0_fifo_data, exp0.pop_front());
            end
            if (instr1_fifo_rd && !instr1_fifo_empty) begin
                if (exp1.size() == 0) check("fifo1_unexpected", instr1_fifo_data, 32'hxxxx_xxxx);
                else check("fifo1_data", instr1_fifo_data, exp1.pop_front());
            end
            if (process_iseq) begin
                if (kick_q.size() == 0) check("kick_unexpected", cyc, 32'hFFFF_FFFF);
                else check("kick_cycle", cyc, kick_q.pop_front());
            end
        end
    end

    // Model dispatcher: busy one cycle after the pulse, drain both slots
    initial begin
        dispatcher_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (process_iseq && rst_n) begin
                disp_active = 1'b1;
                @(posedge clk); #1;
                dispatcher_busy = 1'b1;
                @(posedge clk); #1;
                for (int i = 0; i < 64; i++) begin
                    check("ready_low_busy", in_ready, 32'd0);
                    disp_rd0 = !instr0_fifo_empty;
                    disp_rd1 = !instr1_fifo_empty;
                    if (!disp_rd0 && !disp_rd1) break;
                    if (i == 63) check("drain_timeout", 32'd0, 32'd1);
                    @(posedge clk); #1;
                end
                disp_rd0 = 1'b0;
                disp_rd1 = 1'b0;
                dispatcher_busy = 1'b0;
                @(negedge clk);
                check("ready_busy_fall", in_ready, 32'd0);
                @(negedge clk);
                check("ready_after_fall", in_ready, 32'd1);
                disp_active = 1'b0;
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 32'd0);
        check("rst_process", process_iseq, 32'd0);
        check("rst_overflow", overflow_flush, 32'd0);
        check("rst_empty0", instr0_fifo_empty, 32'd1);
        check("rst_empty1", instr1_fifo_empty, 32'd1);
        check("rst_data0", instr0_fifo_data, 32'd0);
        check("rst_data1", instr1_fifo_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_rst", in_ready, 32'd1);
        @(posedge clk); #1;

        // Odd sequence: NOP pad, kick two cycles after END
        send(32'h1000_000A); send(32'h1000_000B); send(32'h1000_000C); send(W_END);
        wait_idle();

        // Even sequence: no pad, kick one cycle after END
        send(32'h2000_00A1); send(32'h2000_00B2); send(W_END);
        wait_idle();

        // END alone still kicks with empty slots
        send(W_END);
        wait_idle();
        check("empty0_end_only", instr0_fifo_empty, 32'd1);
        check("empty1_end_only", instr1_fifo_empty, 32'd1);

        // Read held on an empty FIFO is ignored
        man_rd0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rd_empty_count", 32'(dut.u_fifo0.count), 32'd0);
        check("rd_empty_flag", instr0_fifo_empty, 32'd1);
        man_rd0 = 1'b0;

        // Simultaneous read and write on slot 0 with two entries held
        send(32'h3000_0001); send(32'h3000_0002); send(32'h3000_0003); send(32'h3000_0004);
        check("cnt0_before_rw", 32'(dut.u_fifo0.count), 32'd2);
        in_valid = 1'b1;
        in_data  = 32'h3000_0005;
        man_rd0  = 1'b1;
        @(negedge clk);
        check("ready_rw", in_ready, 32'd1);
        if (in_ready) model(in_data, cyc);
        @(posedge clk); #1;
        in_valid = 1'b0;
        man_rd0  = 1'b0;
        check("cnt0_after_rw", 32'(dut.u_fifo0.count), 32'd2);
        send(W_END);
        wait_idle();

        // Eight words without END overflow both depth-4 slots
        check("ovf_before", overflow_flush, 32'(m_ovf));
        for (int k = 0; k < 8; k++) send(32'h4000_0000 + 32'(k));
        wait_idle();
        check("ovf_set", overflow_flush, 32'd1);
        send(32'h4000_0009); send(32'h4000_000A); send(W_END);
        wait_idle();
        check("ovf_sticky", overflow_flush, 32'(m_ovf));

        // Reset mid-sequence discards the partial load
        send(32'h5000_000A); send(32'h5000_000B);
        rst_n = 1'b0;
        exp0.delete();
        exp1.delete();
        kick_q.delete();
        m_slot = 1'b0;
        m_ovf  = 1'b0;
        @(negedge clk);
        check("midrst_ready", in_ready, 32'd0);
        check("midrst_empty0", instr0_fifo_empty, 32'd1);
        check("midrst_empty1", instr1_fifo_empty, 32'd1);
        check("midrst_ovf", overflow_flush, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("postrst_empty0", instr0_fifo_empty, 32'd1);
        @(posedge clk); #1;
        send(32'h2345_6789); send(W_END);
        wait_idle();

        repeat (3) @(posedge clk);
        check("kick_pending", kick_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
